slc3_run_ctrl: RTL and testbench
================================

SLC3_RUN_CTRL -- requirements
Module: slc3_run_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable samples required before a button level is accepted.
REQ-002 SHALL have parameter CNT_W, default 16, instruction counter width.
REQ-003 SHALL have port Clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Run  input  1  raw active-low Run button, asynchronous to Clk.
REQ-006 SHALL have port Continue  input  1  raw active-low Continue button, asynchronous to Clk.
REQ-007 SHALL have port pause_req  input  1  one-cycle pulse from the CPU control unit on a PAUSE instruction.
REQ-008 SHALL have port halt_req  input  1  one-cycle pulse from the CPU control unit on a halt.
REQ-009 SHALL have port ifetch_done  input  1  one-cycle pulse per completed instruction fetch.
REQ-010 SHALL have port step_mode  input  1  single-step request, driven from a switch.
REQ-011 SHALL have port cpu_en  output  1  CPU state-machine advance enable.
REQ-012 SHALL have port cpu_start  output  1  one-cycle pulse; CPU resets its PC and begins.
REQ-013 SHALL have port cpu_resume  output  1  one-cycle pulse; CPU leaves its pause state.
REQ-014 SHALL have port run_state  output  3  encoded controller state, for LED display.
REQ-015 SHALL have port instr_count  output  CNT_W  instructions fetched since the last start.

Function
REQ-016 SHALL use, per button, a 2-flop synchronizer, then a debouncer; the stable level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples; a press event is a one-cycle pulse on a stable 1->0 transition.
REQ-017 SHALL treat a button bounce shorter than DEBOUNCE_CYCLES as no event; a held button SHALL produce exactly one press event.
REQ-018 SHALL implement states IDLE=0, START=1, RUNNING=2, PAUSED=3, RESUME=4, HALTED=5, encoded on run_state.
REQ-019 IDLE or HALTED: on a Run press, go to START; Continue presses are ignored.
REQ-020 START: assert cpu_start for exactly one cycle, clear instr_count, and go to RUNNING.
REQ-021 RUNNING: cpu_en=1; on halt_req go to HALTED; otherwise on pause_req go to PAUSED; Run and Continue presses are ignored.
REQ-022 PAUSED: cpu_en=0; on a Continue press go to RESUME; on a Run press go to START (restart).
REQ-023 RESUME: assert cpu_resume for exactly one cycle, cpu_en=1, then go to RUNNING.
REQ-024 cpu_en SHALL be 0 in IDLE, START, PAUSED and HALTED.
REQ-025 If halt_req and pause_req arrive together, halt SHALL win.
REQ-026 A Continue press in the same cycle as pause_req SHALL NOT resume; a new press is required.
REQ-027 instr_count SHALL increment on ifetch_done only while cpu_en=1, and SHALL wrap from all-ones to 0.
REQ-028 instr_count SHALL hold its value in PAUSED and HALTED.

Reset
REQ-029 While Reset=0: state=IDLE, cpu_en=0, cpu_start=0, cpu_resume=0, instr_count=0, debouncer stable levels=1 (released), debounce counters=0, synchronizer flops=1.
REQ-030 Reset asserted mid-operation SHALL abort immediately with no pulse emitted; after release, a button still held SHALL NOT generate a press until it has been released and pressed again.

Configuration
REQ-031 Macro SLC3_STEP_MODE_EN: when defined, RUNNING with step_mode=1 SHALL go to PAUSED on the cycle after ifetch_done, counting that instruction; halt_req still has priority.
REQ-032 When SLC3_STEP_MODE_EN is not defined, the step_mode port SHALL remain present and be ignored.

Structure
REQ-033 Shared package slc3_pkg SHALL hold the run_state_t enum (3-bit, the values in REQ-018) and the default DEBOUNCE_CYCLES constant.
REQ-034 The debounce logic SHALL be a sub-module btn_debounce (sync, counter, stable level, press pulse), instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 Reset release, Run held low for 10 cycles -> one cpu_start pulse 2+4 cycles after the synchronized low (+1 for FSM), run_state 0->1->2, cpu_en=1.
REQ-036 RUNNING, pause_req pulse -> run_state=3 and cpu_en=0 next cycle; Continue held low for 10 cycles -> exactly one cpu_resume, then run_state=2.
REQ-037 Run toggled low/high every 2 cycles for 20 cycles -> no press event and no state change.
REQ-038 pause_req and halt_req asserted in the same cycle -> run_state=5; a later Continue press produces no change; a Run press -> START, instr_count=0.
REQ-039 instr_count preset to 0xFFFF through 0xFFFF ifetch_done pulses, plus one more -> instr_count=0x0000.
REQ-040 With SLC3_STEP_MODE_EN defined and step_mode=1: 3 Continue presses with 3 ifetch_done pulses -> 3 pauses, instr_count=3.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 run controller.
package slc3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_RUNNING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_RESUME  = 3'd4,
        ST_HALTED  = 3'd5
    } run_state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debouncer, one-cycle press pulse
// on a debounced 1->0 transition of an active-low button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          armed;

    // NOTE: until the button has been seen released long enough to outlast the
    // synchronizer's reset value, a held button cannot produce a press event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            armed <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (!armed) begin
                if (!sync2) begin
                    cnt <= '0;
                end else if (cnt == ARM_LAST) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (sync2 != level) begin
                if (cnt == DEB_LAST) begin
                    level <= sync2;
                    press <= ~sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/slc3_run_ctrl.sv
// Run/pause/halt controller for the SLC-3 CPU with debounced Run/Continue buttons.
// Optional single-step pausing is enabled by defining SLC3_STEP_MODE_EN.
module slc3_run_ctrl
    import slc3_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    input  logic             pause_req,
    input  logic             halt_req,
    input  logic             ifetch_done,
    input  logic             step_mode,
    output logic             cpu_en,
    output logic             cpu_start,
    output logic             cpu_resume,
    output logic [2:0]       run_state,
    output logic [CNT_W-1:0] instr_count
);

    run_state_t state;
    logic       run_press;
    logic       cont_press;
    logic       unused_run_level;
    logic       unused_cont_level;
    logic       step_pause;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
        .clk   (Clk),
        .rst_n (Reset),
        .btn   (Run),
        .level (unused_run_level),
        .press (run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_btn (
        .clk   (Clk),
        .rst_n (Reset),
        .btn   (Continue),
        .level (unused_cont_level),
        .press (cont_press)
    );

`ifdef SLC3_STEP_MODE_EN
    assign step_pause = step_mode & ifetch_done;
`else
    logic unused_step_mode;
    assign unused_step_mode = step_mode;
    assign step_pause       = 1'b0;
`endif

    assign run_state = state;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch reads the pre-edge values of state, cpu_en and instr_count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_IDLE;
            cpu_en      <= 1'b0;
            cpu_start   <= 1'b0;
            cpu_resume  <= 1'b0;
            instr_count <= '0;
        end else begin
            cpu_start  <= 1'b0;
            cpu_resume <= 1'b0;
            if (cpu_en && ifetch_done) begin
                instr_count <= instr_count + 1'b1;
            end
            unique case (state)
                ST_IDLE, ST_HALTED: begin
                    if (run_press) begin
                        state       <= ST_START;
                        cpu_start   <= 1'b1;
                        instr_count <= '0;
                    end
                end
                ST_START: begin
                    state  <= ST_RUNNING;
                    cpu_en <= 1'b1;
                end
                ST_RUNNING: begin
                    if (halt_req) begin
                        state  <= ST_HALTED;
                        cpu_en <= 1'b0;
                    end else if (pause_req || step_pause) begin
                        state  <= ST_PAUSED;
                        cpu_en <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (cont_press) begin
                        state      <= ST_RESUME;
                        cpu_resume <= 1'b1;
                        cpu_en     <= 1'b1;
                    end else if (run_press) begin
                        state       <= ST_START;
                        cpu_start   <= 1'b1;
                        instr_count <= '0;
                    end
                end
                ST_RESUME: begin
                    state <= ST_RUNNING;
                end
                default: begin
                    state  <= ST_IDLE;
                    cpu_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_run_ctrl.sv
// Directed bench for slc3_run_ctrl with DEBOUNCE_CYCLES=4, CNT_W=16.
module tb_slc3_run_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        Continue;
    logic        pause_req;
    logic        halt_req;
    logic        ifetch_done;
    logic        step_mode;
    logic        cpu_en;
    logic        cpu_start;
    logic        cpu_resume;
    logic [2:0]  run_state;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    int starts;
    int resumes;
    int pauses;

    slc3_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .Continue    (Continue),
        .pause_req   (pause_req),
        .halt_req    (halt_req),
        .ifetch_done (ifetch_done),
        .step_mode   (step_mode),
        .cpu_en      (cpu_en),
        .cpu_start   (cpu_start),
        .cpu_resume  (cpu_resume),
        .run_state   (run_state),
        .instr_count (instr_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Advance n cycles, counting cpu_start and cpu_resume pulses seen.
    task automatic run_cycles(input int n, output int s, output int r);
        s = 0;
        r = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            s += int'(cpu_start);
            r += int'(cpu_resume);
        end
    endtask

    // Full Continue press-and-release; returns resume pulses observed.
    task automatic press_continue(output int r);
        int s1, r1, s2, r2;
        Continue = 1'b0;
        run_cycles(10, s1, r1);
        Continue = 1'b1;
        run_cycles(8, s2, r2);
        r = r1 + r2;
    endtask

    initial begin
        Reset = 1'b0; Run = 1'b1; Continue = 1'b1;
        pause_req = 1'b0; halt_req = 1'b0; ifetch_done = 1'b0; step_mode = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(run_state), 32'd0);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_cpu_start", 32'(cpu_start), 32'd0);
        check("rst_cpu_resume", 32'(cpu_resume), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);

        Reset = 1'b1;
        repeat (10) tick();
        check("idle_state", 32'(run_state), 32'd0);

        // Run press: 2 sync + 4 debounce cycles, then one FSM cycle.
        Run = 1'b0;
        repeat (6) tick();
        check("pre_start_idle", 32'(run_state), 32'd0);
        tick();
        check("start_state", 32'(run_state), 32'd1);
        check("start_pulse", 32'(cpu_start), 32'd1);
        check("start_cpu_en", 32'(cpu_en), 32'd0);
        tick();
        check("running_state", 32'(run_state), 32'd2);
        check("running_cpu_en", 32'(cpu_en), 32'd1);
        check("start_pulse_end", 32'(cpu_start), 32'd0);
        run_cycles(2, starts, resumes);
        Run = 1'b1;
        run_cycles(10, starts, resumes);
        check("held_run_one_start", 32'(starts), 32'd0);
        check("still_running", 32'(run_state), 32'd2);

        for (int i = 0; i < 3; i++) begin
            ifetch_done = 1'b1;
            tick();
            ifetch_done = 1'b0;
            tick();
        end
        check("count_three", 32'(instr_count), 32'd3);

        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        check("paused_state", 32'(run_state), 32'd3);
        check("paused_cpu_en", 32'(cpu_en), 32'd0);
        ifetch_done = 1'b1;
        tick();
        ifetch_done = 1'b0;
        check("paused_count_hold", 32'(instr_count), 32'd3);

        // Bouncing Run in PAUSED must not restart.
        pauses = 0;
        for (int i = 0; i < 5; i++) begin
            Run = 1'b0;
            run_cycles(2, starts, resumes);
            pauses += starts;
            Run = 1'b1;
            run_cycles(2, starts, resumes);
            pauses += starts;
        end
        run_cycles(8, starts, resumes);
        pauses += starts;
        check("bounce_no_start", 32'(pauses), 32'd0);
        check("bounce_state", 32'(run_state), 32'd3);

        press_continue(resumes);
        check("continue_one_resume", 32'(resumes), 32'd1);
        check("continue_running", 32'(run_state), 32'd2);
        check("continue_cpu_en", 32'(cpu_en), 32'd1);

        // Continue press lands in the same cycle as pause_req.
        Continue = 1'b0;
        repeat (6) tick();
        pause_req = 1'b1;
        tick();
        pause_req = 1'b0;
        check("same_cycle_paused", 32'(run_state), 32'd3);
        run_cycles(6, starts, resumes);
        pauses = resumes;
        Continue = 1'b1;
        run_cycles(8, starts, resumes);
        check("same_cycle_no_resume", 32'(pauses + resumes), 32'd0);
        check("same_cycle_still_paused", 32'(run_state), 32'd3);
        press_continue(resumes);
        check("new_press_resume", 32'(resumes), 32'd1);
        check("new_press_running", 32'(run_state), 32'd2);

        // Halt beats pause.
        pause_req = 1'b1;
        halt_req  = 1'b1;
        tick();
        pause_req = 1'b0;
        halt_req  = 1'b0;
        check("halt_wins", 32'(run_state), 32'd5);
        check("halt_cpu_en", 32'(cpu_en), 32'd0);
        check("halt_count_hold", 32'(instr_count), 32'd3);
        press_continue(resumes);
        check("halt_continue_ignored", 32'(run_state), 32'd5);
        check("halt_no_resume", 32'(resumes), 32'd0);
        Run = 1'b0;
        repeat (7) tick();
        check("restart_state", 32'(run_state), 32'd1);
        check("restart_count_clear", 32'(instr_count), 32'd0);
        tick();
        check("restart_running", 32'(run_state), 32'd2);
        Run = 1'b1;
        run_cycles(8, starts, resumes);

        // Counter wrap.
        ifetch_done = 1'b1;
        repeat (65535) tick();
        ifetch_done = 1'b0;
        check("count_all_ones", 32'(instr_count), 32'h0000_FFFF);
        ifetch_done = 1'b1;
        tick();
        ifetch_done = 1'b0;
        check("count_wrap", 32'(instr_count), 32'd0);

        step_mode = 1'b1;
        pauses = 0;
        for (int i = 0; i < 3; i++) begin
            ifetch_done = 1'b1;
            tick();
            ifetch_done = 1'b0;
            pauses += int'(run_state == 3'd3);
`ifdef SLC3_STEP_MODE_EN
            press_continue(resumes);
`else
            tick();
`endif
        end
`ifdef SLC3_STEP_MODE_EN
        check("step_pauses", 32'(pauses), 32'd3);
`else
        check("step_ignored", 32'(pauses), 32'd0);
`endif
        check("step_count", 32'(instr_count), 32'd3);
        check("step_end_running", 32'(run_state), 32'd2);
        step_mode = 1'b0;

        // Reset mid-run with Run held through release.
        Run = 1'b0;
        run_cycles(3, starts, resumes);
        Reset = 1'b0;
        #2;
        check("mid_reset_state", 32'(run_state), 32'd0);
        check("mid_reset_cpu_en", 32'(cpu_en), 32'd0);
        check("mid_reset_count", 32'(instr_count), 32'd0);
        tick();
        Reset = 1'b1;
        run_cycles(20, starts, resumes);
        check("held_after_reset_no_start", 32'(starts), 32'd0);
        check("held_after_reset_idle", 32'(run_state), 32'd0);
        Run = 1'b1;
        run_cycles(10, starts, resumes);
        Run = 1'b0;
        repeat (7) tick();
        check("rearmed_start", 32'(run_state), 32'd1);
        Run = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
